// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_ctrl
// Brief    : 6-bit successive-approximation ADC controller driving an external
//            DAC and reading an external comparator. Optional 4x oversampling
//            accumulator is compiled in with `SAR_OVERSAMPLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sar_adc_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] c_sync_m1   = 5'(SYNC_STAGES - 1);
    localparam logic [5:0] c_first_try = 6'b100000;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_start_q;
    logic                   r_start_q2;
    logic [3:0]             r_settle;
    logic [4:0]             r_cnt;
    logic [2:0]             r_bit;
    logic [5:0]             r_dac;
    logic [7:0]             r_uo;
    logic                   r_busy;
    logic                   r_done;

`ifdef SAR_OVERSAMPLE_EN
    logic                   r_avg;
    logic [1:0]             r_sub;
    logic [7:0]             r_acc;
`endif

    logic       w_comp;
    logic       w_start_edge;
    logic       w_begin;
    logic       w_more_subs;
    logic [5:0] w_kept;
    logic [5:0] w_next_try;
    logic [4:0] w_cnt_new;
    logic [4:0] w_cnt_hold;
    logic [7:0] w_result;
    logic       w_unused;

    assign w_comp       = r_sync[SYNC_STAGES-1];
    assign w_start_edge = r_start_q & ~r_start_q2;
    // A new conversion starts from IDLE on a start edge, or straight out of DONE in continuous mode.
    assign w_begin      = ((r_state == ST_IDLE) && w_start_edge) ||
                          ((r_state == ST_DONE) && ui_in[2]);
    assign w_kept       = w_comp ? r_dac : (r_dac & ~(6'd1 << r_bit));
    assign w_next_try   = w_kept | (6'd1 << (r_bit - 3'd1));
    assign w_cnt_new    = {1'b0, ui_in[7:4]} + c_sync_m1;
    assign w_cnt_hold   = {1'b0, r_settle} + c_sync_m1;

`ifdef SAR_OVERSAMPLE_EN
    assign w_more_subs  = r_avg && (r_sub != 2'd3);
    assign w_result     = r_avg ? (r_acc + {2'b00, w_kept}) : {2'b00, w_kept};
`else
    assign w_more_subs  = 1'b0;
    assign w_result     = {2'b00, w_kept};
`endif

    assign w_unused = &{1'b0, uio_in, ui_in[3]};

    assign uo_out  = r_uo;
    assign uio_out = {r_done, r_busy, r_dac};
    assign uio_oe  = 8'hFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sync     <= '0;
            r_start_q  <= 1'b0;
            r_start_q2 <= 1'b0;
            r_settle   <= '0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_dac      <= '0;
            r_uo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef SAR_OVERSAMPLE_EN
            r_avg      <= 1'b0;
            r_sub      <= '0;
            r_acc      <= '0;
`endif
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], ui_in[0]};
            r_start_q  <= ui_in[1];
            r_start_q2 <= r_start_q;
            r_done     <= 1'b0;

            if (!ena) begin
                r_state <= ST_IDLE;
                r_dac   <= '0;
                r_busy  <= 1'b0;
            end else if (w_begin) begin
                r_state  <= ST_SETTLE;
                r_settle <= ui_in[7:4];
                r_cnt    <= w_cnt_new;
                r_bit    <= 3'd5;
                r_dac    <= c_first_try;
                r_busy   <= 1'b1;
`ifdef SAR_OVERSAMPLE_EN
                r_avg    <= ui_in[3];
                r_sub    <= '0;
                r_acc    <= '0;
`endif
            end else begin
                case (r_state)
                    ST_SETTLE: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        if (r_bit != 3'd0) begin
                            r_bit   <= r_bit - 3'd1;
                            r_dac   <= w_next_try;
                            r_cnt   <= w_cnt_hold;
                            r_state <= ST_SETTLE;
                        end else if (w_more_subs) begin
                            // Next oversampling pass: stay busy, no DONE in between.
                            r_bit   <= 3'd5;
                            r_dac   <= c_first_try;
                            r_cnt   <= w_cnt_hold;
                            r_state <= ST_SETTLE;
`ifdef SAR_OVERSAMPLE_EN
                            r_acc   <= r_acc + {2'b00, w_kept};
                            r_sub   <= r_sub + 2'd1;
`endif
                        end else begin
                            r_dac   <= w_kept;
                            r_uo    <= w_result;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_dac   <= '0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_dac   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_ctrl
// Brief    : Self-checking bench for sar_adc_ctrl with an ideal comparator and
//            a cycle-level conversion model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_ctrl;

    localparam int SYNC_STAGES = 2;
`ifdef SAR_OVERSAMPLE_EN
    localparam bit C_OS = 1'b1;
`else
    localparam bit C_OS = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] uio_in = 8'hA5;
    wire  [7:0] ui_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    logic [3:0] tb_S     = 4'd0;
    logic       tb_os    = 1'b0;
    logic       tb_cont  = 1'b0;
    logic       tb_start = 1'b0;
    int         tb_analog = 0;

    // Ideal comparator: high while the analog level is at or above the DAC code.
    assign ui_in = {tb_S, tb_os, tb_cont, tb_start, (tb_analog >= int'(uio_out[5:0]))};

    sar_adc_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // DAC trial code presented for step k (0 = MSB) of an ideal SAR search.
    function automatic logic [5:0] trial(int an, int k);
        int code = 0;
        int t    = 0;
        for (int i = 5; i >= 0; i--) begin
            t = code | (1 << i);
            if (5 - i == k) return 6'(t);
            if (an >= t) code = t;
        end
        return 6'(code);
    endfunction

    bit         m_active  = 1'b0;
    bit         m_armed   = 1'b0;
    bit         m_restart = 1'b0;
    int         m_cyc     = 0;
    int         m_S       = 0;
    int         m_nsub    = 1;
    int         m_an[4]   = '{0, 0, 0, 0};
    logic [7:0] m_uo      = 8'd0;
    logic       ena_q     = 1'b1;
    int         mp, ml, msub, mk;
    logic [7:0] m_exp_uo;

    always @(posedge clk) ena_q <= ena;
    always @(negedge clk) if (rst_n && uio_out[7]) n_done++;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_uo", uo_out, 8'd0);
            check("rst_uio", uio_out, 8'd0);
            m_active = 1'b0; m_restart = 1'b0; m_uo = 8'd0;
        end else if (!ena_q) begin
            check("ena_uio", uio_out, 8'd0);
            check("ena_uo", uo_out, m_uo);
            m_active = 1'b0; m_restart = 1'b0;
        end else begin
            check("oe", uio_oe, 8'hFF);
            if (!m_active && uio_out[6]) begin
                if (!(m_armed || m_restart)) begin
                    n_fail++;
                    $display("FAIL spurious_start: busy rose without a start at %0t", $time);
                end
                m_active = 1'b1; m_cyc = 0; m_armed = 1'b0; m_restart = 1'b0;
                m_S = int'(tb_S);
                m_nsub = (C_OS && tb_os) ? 4 : 1;
            end else if (!m_active) begin
                if (m_restart) begin
                    n_fail++;
                    $display("FAIL restart: busy 0, expected continuous restart at %0t", $time);
                end
                m_restart = 1'b0;
                check("idle_uio", uio_out, 8'd0);
                check("idle_uo", uo_out, m_uo);
            end
            if (m_active) begin
                mp = m_S + SYNC_STAGES + 1;
                ml = 6 * mp;
                if (m_cyc == m_nsub * ml) begin
                    m_exp_uo = (m_nsub == 4) ? 8'(m_an[0] + m_an[1] + m_an[2] + m_an[3])
                                             : 8'(m_an[0]);
                    check("done_uio", uio_out, {2'b10, 6'(m_an[m_nsub-1])});
                    check("done_uo", uo_out, m_exp_uo);
                    m_uo = m_exp_uo; m_active = 1'b0; m_restart = tb_cont;
                end else begin
                    msub = m_cyc / ml;
                    mk   = (m_cyc % ml) / mp;
                    tb_analog = m_an[msub];
                    check("conv_uio", uio_out, {2'b01, trial(m_an[msub], mk)});
                    check("conv_uo", uo_out, m_uo);
                end
                m_cyc++;
            end
        end
    end

    logic [5:0] dac_seq[$];
    logic [5:0] exp_seq[6] = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};

    task automatic start_conv(input int s, input int an, input bit cont, input bit os);
        @(posedge clk); #1;
        tb_S = 4'(s); tb_cont = cont; tb_os = os;
        m_an[0] = an; tb_analog = an; m_armed = 1'b1; tb_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tb_start = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!uio_out[6] && n < 6);
        n_tests++;
        if (!uio_out[6]) begin
            n_fail++;
            $display("FAIL %s: busy 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Waits for done, recording DAC changes; at cycle 'poke' the settle count and continuous bit are cleared.
    task automatic wait_done(input string name, input int budget, input int poke, output int cyc);
        cyc = 0;
        dac_seq.delete();
        dac_seq.push_back(uio_out[5:0]);
        while (!uio_out[7] && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin tb_S = 4'd0; tb_cont = 1'b0; end
            if (uio_out[6] && uio_out[5:0] != dac_seq[$]) dac_seq.push_back(uio_out[5:0]);
        end
        n_tests++;
        if (!uio_out[7]) begin
            n_fail++;
            $display("FAIL %s: done 0 after %0d cycles, expected 1", name, cyc);
        end
    endtask

    int lat;
    int d0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_oe", uio_oe, 8'hFF);
        check("reset_uo", uo_out, 8'd0);
        check("reset_uio", uio_out, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Level 37, S = 0
        start_conv(0, 37, 1'b0, 1'b0);
        wait_busy("t1_busy");
        wait_done("t1_done", 40, -1, lat);
        check("t1_latency", 8'(lat), 8'd18);
        check("t1_nsteps", 8'(dac_seq.size()), 8'd6);
        for (int i = 0; i < 6; i++)
            if (i < dac_seq.size()) check("t1_dac_step", {2'b00, dac_seq[i]}, {2'b00, exp_seq[i]});
        check("t1_uo", uo_out, 8'd37);
        repeat (4) @(negedge clk);

        // Levels 63 then 0 with S = 15; settle count altered mid-run
        start_conv(15, 63, 1'b0, 1'b0);
        wait_busy("t2a_busy");
        wait_done("t2a_done", 200, 50, lat);
        check("t2a_latency", 8'(lat), 8'd108);
        check("t2a_uo", uo_out, 8'd63);
        start_conv(15, 0, 1'b0, 1'b0);
        wait_busy("t2b_busy");
        wait_done("t2b_done", 200, -1, lat);
        check("t2b_latency", 8'(lat), 8'd108);
        check("t2b_uo", uo_out, 8'd0);
        repeat (4) @(negedge clk);

        // Start pulse while busy
        start_conv(0, 37, 1'b0, 1'b0);
        wait_busy("t3_busy");
        d0 = n_done;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 tb_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 tb_start = 1'b0;
        wait_done("t3_done", 40, -1, lat);
        repeat (10) @(negedge clk);
        check("t3_done_count", 8'(n_done - d0), 8'd1);
        check("t3_uo", uo_out, 8'd37);

        // Reset during SETTLE of bit 2
        start_conv(0, 26, 1'b0, 1'b0);
        wait_busy("t4_busy");
        d0 = n_done;
        repeat (9) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("t4_rst_uo", uo_out, 8'd0);
        check("t4_rst_uio", uio_out, 8'd0);
        check("t4_rst_oe", uio_oe, 8'hFF);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_no_done", 8'(n_done - d0), 8'd0);
        start_conv(0, 50, 1'b0, 1'b0);
        wait_busy("t4b_busy");
        wait_done("t4b_done", 40, -1, lat);
        check("t4b_uo", uo_out, 8'd50);
        repeat (4) @(negedge clk);

        // Continuous mode: 20 then 45, then stop
        start_conv(0, 20, 1'b1, 1'b0);
        wait_busy("t5_busy");
        wait_done("t5a_done", 40, -1, lat);
        check("t5a_uo", uo_out, 8'd20);
        @(posedge clk); #1 m_an[0] = 45; tb_analog = 45;
        @(negedge clk);
        check("t5_b2b_busy", {7'd0, uio_out[6]}, 8'd1);
        wait_done("t5b_done", 40, 5, lat);
        check("t5b_uo", uo_out, 8'd45);
        repeat (8) @(negedge clk);
        check("t5_stopped", {7'd0, uio_out[6]}, 8'd0);

        // Enable dropped mid-conversion
        start_conv(0, 33, 1'b0, 1'b0);
        wait_busy("t6_busy");
        repeat (4) @(negedge clk);
        @(posedge clk); #1 ena = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_ena_uio", uio_out, 8'd0);
        check("t6_ena_uo", uo_out, 8'd45);
        @(posedge clk); #1 ena = 1'b1;
        repeat (3) @(negedge clk);
        start_conv(0, 33, 1'b0, 1'b0);
        wait_busy("t6b_busy");
        wait_done("t6b_done", 40, -1, lat);
        check("t6b_uo", uo_out, 8'd33);
        repeat (4) @(negedge clk);

        // Average-mode request
`ifdef SAR_OVERSAMPLE_EN
        m_an[1] = 11; m_an[2] = 12; m_an[3] = 13;
        start_conv(0, 10, 1'b0, 1'b1);
        wait_busy("t7_busy");
        d0 = n_done;
        wait_done("t7_done", 120, -1, lat);
        repeat (5) @(negedge clk);
        check("t7_latency", 8'(lat), 8'd72);
        check("t7_done_count", 8'(n_done - d0), 8'd1);
        check("t7_uo", uo_out, 8'd46);
`else
        start_conv(0, 29, 1'b0, 1'b1);
        wait_busy("t7_busy");
        d0 = n_done;
        wait_done("t7_done", 40, -1, lat);
        repeat (5) @(negedge clk);
        check("t7_latency", 8'(lat), 8'd18);
        check("t7_done_count", 8'(n_done - d0), 8'd1);
        check("t7_uo", uo_out, 8'd29);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
